// File: rtl/confronto_seriale_lsb.sv
// Bit-serial unsigned magnitude comparator, LSB first.
// Later differing bits override earlier ones, giving MSB-priority results.
module confronto_seriale_lsb #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic xb,
  input  logic yb,
  output logic busy,
  output logic done,
  output logic gt,
  output logic eq,
  output logic lt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    R_EQ,
    R_GT,
    R_LT
  } rel_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state_q, state_d;
  rel_t          rel_q, rel_d, rel_nx;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    res_q, res_d;
  logic          done_q, done_d;

  // Relation after folding in the current bit pair.
  always_comb begin
    rel_nx = rel_q;
    if (xb && !yb) begin
      rel_nx = R_GT;
    end else if (!xb && yb) begin
      rel_nx = R_LT;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rel_d   = rel_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = '0;
          rel_d   = R_EQ;
        end
      end
      S_RUN: begin
        if (bit_valid) begin
          rel_d = rel_nx;
          if (count_q == LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            res_d   = {rel_nx == R_GT,
                       rel_nx == R_EQ,
                       rel_nx == R_LT};
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rel_q   <= R_EQ;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rel_q   <= rel_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign gt   = res_q[2];
  assign eq   = res_q[1];
  assign lt   = res_q[0];

endmodule

// File: tb/tb_confronto_seriale_lsb.sv
// Bench for confronto_seriale_lsb: fixed vectors, corner sequences,
// and random operands checked against an arithmetic reference.
module tb_confronto_seriale_lsb;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst, start, bit_valid, xb, yb;
  logic busy, done, gt, eq, lt;

  int n_vec = 0;
  int n_bad = 0;
  logic [2:0] prev;

  confronto_seriale_lsb #(.N(N), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bit_valid(bit_valid), .xb(xb), .yb(yb),
    .busy(busy), .done(done),
    .gt(gt), .eq(eq), .lt(lt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         gap_at;
    int         gap_len;
    int         restart_at;
    bit         b2b;
    logic [2:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [2:0] got,
                     input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model(input logic [7:0] x,
                                       input logic [7:0] y);
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  task automatic chk_run();
    chk("busy_run", {2'b0, busy}, 3'b001);
    chk("done_low", {2'b0, done}, 3'b000);
    chk("held_res", {gt, eq, lt}, prev);
  endtask

  // Start driven with a decoy bit pair that must be ignored.
  task automatic run_cmp(input logic [7:0] x,
                         input logic [7:0] y,
                         input int gap_at,
                         input int gap_len,
                         input int restart_at,
                         input logic [2:0] exp);
    start = 1'b1;
    bit_valid = 1'b1;
    xb = ~y[N-1];
    yb = y[N-1];
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bit_valid = 1'b0;
          xb = 1'($urandom);
          yb = 1'($urandom);
          chk_run();
          tick();
        end
      end
      start = (i == restart_at);
      bit_valid = 1'b1;
      xb = x[i];
      yb = y[i];
      chk_run();
      tick();
    end
    start = 1'b0;
    bit_valid = 1'b0;
    chk("done_pulse", {2'b0, done}, 3'b001);
    chk("busy_done", {2'b0, busy}, 3'b000);
    chk("result", {gt, eq, lt}, exp);
    prev = exp;
  endtask

  task automatic idle_after();
    tick();
    chk("done_one", {2'b0, done}, 3'b000);
    chk("busy_idle", {2'b0, busy}, 3'b000);
    chk("hold_res", {gt, eq, lt}, prev);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'hA5, 8'h5A, -1, 0, -1, 1'b0, 3'b100};
    tbl[1] = '{8'h3C, 8'h3C, -1, 0, -1, 1'b0, 3'b010};
    tbl[2] = '{8'h03, 8'h04, -1, 0, -1, 1'b0, 3'b001};
    tbl[3] = '{8'h80, 8'h7F,  3, 3, -1, 1'b0, 3'b100};
    tbl[4] = '{8'h12, 8'h34, -1, 0,  4, 1'b1, 3'b001};
    tbl[5] = '{8'hFF, 8'hFE, -1, 0, -1, 1'b0, 3'b100};

    rst = 1'b1;
    start = 1'b1;
    bit_valid = 1'b1;
    xb = 1'b1;
    yb = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    prev = 3'b000;
    chk("rst_busy", {2'b0, busy}, 3'b000);
    chk("rst_done", {2'b0, done}, 3'b000);
    chk("rst_res", {gt, eq, lt}, 3'b000);
    tick();
    chk("idle_busy", {2'b0, busy}, 3'b000);

    foreach (tbl[k]) begin
      run_cmp(tbl[k].x, tbl[k].y, tbl[k].gap_at,
              tbl[k].gap_len, tbl[k].restart_at, tbl[k].exp);
      if (!tbl[k].b2b) idle_after();
    end

    // Abort at bit 5 with rst and start together.
    idle_after();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      xb = 1'b1;
      yb = 1'b0;
      chk_run();
      tick();
    end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    bit_valid = 1'b0;
    prev = 3'b000;
    chk("abort_busy", {2'b0, busy}, 3'b000);
    chk("abort_done", {2'b0, done}, 3'b000);
    chk("abort_res", {gt, eq, lt}, 3'b000);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_nodone", {1'b0, done, busy}, 3'b000);
    end
    run_cmp(8'h10, 8'h0F, -1, 0, -1, 3'b100);
    idle_after();

    for (int r = 0; r < 40; r++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = x ^ (8'h01 << $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      run_cmp(x, y, $urandom_range(0, N - 1),
              $urandom_range(0, 4),
              $urandom_range(0, N + 3), model(x, y));
      if ($urandom_range(0, 1) == 0) idle_after();
    end
    idle_after();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
